// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the scan driver and the capture block.
// Patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   localparam logic [15:0][6:0] SEG_TBL = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                           SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

   localparam logic [3:0] POS_BLANK = 4'b1111;

   typedef struct packed {
      logic [3:0] pos;
      logic [6:0] dout;
   } sample_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] nib;
   } dec_t;
endpackage

// File: rtl/seg_decode.sv
// Combinational segment-pattern to hex-nibble decoder; hit is low for
// patterns that are not one of the 16 glyphs.
module seg_decode
   import seg_pkg::*;
(
   input  logic [6:0] pat,
   output dec_t       dec
);
   always_comb begin
      dec = '0;
      for (int k = 0; k < 16; k++) begin
         if (pat == SEG_TBL[k]) begin
            dec.hit = 1'b1;
            dec.nib = 4'(k);
         end
      end
   end
endmodule

// File: rtl/seg_capture.sv
// Captures a scanned four-digit seven-segment display back into nibbles.
// Define SEG_CAPTURE_SYNC_EN to add a 2-flop input synchronizer for off-chip pins.
module seg_capture
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 250_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] pos,
   input  logic [6:0] dout,
   output logic [3:0] n1,
   output logic [3:0] n2,
   output logic [3:0] n3,
   output logic [3:0] n4,
   output logic [3:0] valid,
   output logic       frame_done,
   output logic       seg_err
);
   localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0]  CNT_PRE = 8'(STABLE_CYCLES - 2);
   localparam logic [27:0] AGE_MAX = 28'(TIMEOUT);

   sample_t s;

`ifdef SEG_CAPTURE_SYNC_EN
   sample_t sync1_q, sync2_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '1;
         sync2_q <= '1;
      end else begin
         sync1_q <= {pos, dout};
         sync2_q <= sync1_q;
      end
   end
   assign s = sync2_q;
`else
   assign s = {pos, dout};
`endif

   sample_t          prev_q, prev_d;
   logic [7:0]       cnt_q, cnt_d;
   logic [3:0][3:0]  nib_q, nib_d;
   logic [3:0][27:0] age_q, age_d;
   logic [3:0]       valid_q, valid_d, seen_q, seen_d;
   logic             frame_q, frame_d, err_q, err_d;

   logic       commit, one_hot, multi;
   logic [3:0] sel;
   dec_t       dec;

   seg_decode u_dec (.pat(prev_q.dout), .dec(dec));

   // Commit fires on the single edge where the run length reaches STABLE_CYCLES.
   assign commit  = (s == prev_q) && (cnt_q == CNT_PRE);
   assign sel     = ~prev_q.pos;
   assign one_hot = commit && $onehot(sel);
   assign multi   = commit && (prev_q.pos != POS_BLANK) && !$onehot(sel);

   always_comb begin
      prev_d = prev_q;
      cnt_d  = cnt_q;
      if (s != prev_q) begin
         prev_d = s;
         cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_comb begin
      nib_d   = nib_q;
      valid_d = valid_q;
      age_d   = age_q;
      frame_d = (seen_q == 4'hF);
      seen_d  = (seen_q == 4'hF) ? 4'h0 : seen_q;
      err_d   = multi || (one_hot && !dec.hit);
      for (int i = 0; i < 4; i++) begin
         if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 28'd1;
         if (age_d[i] == AGE_MAX) valid_d[i] = 1'b0;
         // A commit to this digit overrides the staleness timeout.
         if (one_hot && sel[i]) begin
            if (dec.hit) begin
               nib_d[i]   = dec.nib;
               valid_d[i] = 1'b1;
               age_d[i]   = '0;
               seen_d[i]  = 1'b1;
            end else begin
               valid_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q  <= '1;
         cnt_q   <= '0;
         nib_q   <= '0;
         age_q   <= '0;
         valid_q <= '0;
         seen_q  <= '0;
         frame_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         cnt_q   <= cnt_d;
         nib_q   <= nib_d;
         age_q   <= age_d;
         valid_q <= valid_d;
         seen_q  <= seen_d;
         frame_q <= frame_d;
         err_q   <= err_d;
      end
   end

   assign n1         = nib_q[0];
   assign n2         = nib_q[1];
   assign n3         = nib_q[2];
   assign n4         = nib_q[3];
   assign valid      = valid_q;
   assign frame_done = frame_q;
   assign seg_err    = err_q;
endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed steps plus random scan traffic
// against a run-length / timestamp reference model.
module tb_seg_capture;
   localparam int STABLE = 4;
   localparam int TMO    = 50;
`ifdef SEG_CAPTURE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] pos = 4'hF;
   logic [6:0] dout = 7'h7F;
   logic [3:0] n1, n2, n3, n4, valid;
   logic       frame_done, seg_err;

   seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .pos(pos), .dout(dout),
      .n1(n1), .n2(n2), .n3(n3), .n4(n4), .valid(valid),
      .frame_done(frame_done), .seg_err(seg_err)
   );

   always #5 clk = ~clk;

   // glyph table, active-low {g..a}, index = nibble
   logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [10:0] m_last, m_sd1, m_sd2;
   int          m_run;
   logic [3:0]  m_n [4];
   logic [3:0]  m_vf, m_seen;
   int          m_lg [4];
   logic        m_pend, e_frame, e_err;
   int          edge_n = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last = 11'h7FF; m_sd1 = 11'h7FF; m_sd2 = 11'h7FF; m_run = 1;
      for (int i = 0; i < 4; i++) begin m_n[i] = 4'h0; m_lg[i] = 0; end
      m_vf = 4'h0; m_seen = 4'h0; m_pend = 1'b0; e_frame = 1'b0; e_err = 1'b0;
   endtask

   function automatic logic [3:0] exp_valid();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_vf[i] && ((edge_n - m_lg[i]) < TMO);
      return v;
   endfunction

   task automatic model_commit(input logic [10:0] s);
      logic [3:0] p;
      int zeros, idx, hit;
      p = s[10:7];
      zeros = 0; idx = 0; hit = -1;
      for (int b = 0; b < 4; b++) if (!p[b]) begin zeros++; idx = b; end
      for (int k = 0; k < 16; k++) if (glyph[k] == s[6:0]) hit = k;
      if (zeros > 1) e_err = 1'b1;
      else if (zeros == 1) begin
         if (hit >= 0) begin
            m_n[idx] = 4'(hit); m_vf[idx] = 1'b1; m_lg[idx] = edge_n; m_seen[idx] = 1'b1;
            if (m_seen == 4'hF) m_pend = 1'b1;
         end else begin
            e_err = 1'b1; m_vf[idx] = 1'b0;
         end
      end
   endtask

   task automatic model_edge();
      logic [10:0] s;
      edge_n++;
      s = {pos, dout};
      if (LAT != 0) begin s = m_sd2; m_sd2 = m_sd1; m_sd1 = {pos, dout}; end
      e_frame = m_pend;
      if (m_pend) begin m_seen = 4'h0; m_pend = 1'b0; end
      e_err = 1'b0;
      if (s == m_last) begin if (m_run < 1000) m_run++; end
      else begin m_last = s; m_run = 1; end
      if (m_run == STABLE) model_commit(s);
   endtask

   task automatic compare_all();
      chk("n1", n1, m_n[0]); chk("n2", n2, m_n[1]);
      chk("n3", n3, m_n[2]); chk("n4", n4, m_n[3]);
      chk("valid", valid, exp_valid());
      chk("frame_done", frame_done, e_frame);
      chk("seg_err", seg_err, e_err);
   endtask

   task automatic step(input logic [3:0] p, input logic [6:0] d);
      pos = p; dout = d;
      @(posedge clk); #1;
      model_edge();
      compare_all();
   endtask

   task automatic hold(input logic [3:0] p, input logic [6:0] d, input int n);
      for (int k = 0; k < n; k++) step(p, d);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_n"}, {n4, n3, n2, n1}, 16'h0);
      chk({tag, "_valid"}, valid, 4'h0);
      chk({tag, "_pulses"}, {frame_done, seg_err}, 2'b00);
   endtask

   initial begin
      logic [3:0] p;
      logic [6:0] d;
      int kind, len;
      model_reset();
      #2 rst_n = 1'b0;
      #1 check_zero("reset");
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // single digit 3 on digit 1
      hold(4'b1110, glyph[3], 3 + LAT);
      chk("pre_commit_valid", valid, 4'h0);
      step(4'b1110, glyph[3]);
      chk("t1_n1", n1, 4'h3); chk("t1_valid", valid, 4'b0001); chk("t1_err", seg_err, 1'b0);

      // full frame 1,2,A,F
      hold(4'b1110, glyph[1], 10);
      hold(4'b1101, glyph[2], 10);
      hold(4'b1011, glyph[10], 10);
      hold(4'b0111, glyph[15], 4 + LAT);
      chk("frame_at_commit", frame_done, 1'b0);
      step(4'b0111, glyph[15]);
      chk("frame_pulse", frame_done, 1'b1);
      step(4'b0111, glyph[15]);
      chk("frame_one_wide", frame_done, 1'b0);
      hold(4'b0111, glyph[15], 4);
      chk("t2_digits", {n1, n2, n3, n4}, 16'h12AF);
      chk("t2_valid", valid, 4'hF);

      // 3-cycle glitch never commits
      hold(4'b1101, glyph[7], 3);
      hold(4'b1111, 7'h7F, 4 + LAT);
      chk("glitch_n2", n2, 4'h2);

      // illegal pos, then undecodable pattern on digit 1
      hold(4'b1100, glyph[8], 4 + LAT);
      chk("multi_err", seg_err, 1'b1);
      step(4'b1100, glyph[8]);
      chk("multi_err_once", seg_err, 1'b0);
      hold(4'b1110, 7'h7F, 4 + LAT);
      chk("bad_dout_err", seg_err, 1'b1);
      chk("bad_dout_valid0", valid[0], 1'b0);
      chk("bad_dout_n1_held", n1, 4'h1);

      // staleness on digit 3
      hold(4'b1011, glyph[6], 4 + LAT);
      hold(4'b1111, 7'h7F, TMO - 1);
      chk("tmo_still_valid", valid[2], 1'b1);
      step(4'b1111, 7'h7F);
      chk("tmo_cleared", valid[2], 1'b0);
      chk("tmo_n3_held", n3, 4'h6);

      // reset mid-hold
      hold(4'b1101, glyph[9], 3);
      rst_n = 1'b0;
      model_reset();
      #1 check_zero("mid_reset");
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      hold(4'b1110, glyph[5], 4 + LAT);
      chk("post_reset_n1", n1, 4'h5);
      chk("post_reset_valid", valid, 4'b0001);

      // random scan traffic
      for (int it = 0; it < 300; it++) begin
         kind = $urandom_range(0, 9);
         p = ~(4'd1 << $urandom_range(0, 3));
         d = glyph[$urandom_range(0, 15)];
         len = $urandom_range(4, 8) + LAT;
         case (kind)
            6: d = 7'($urandom);
            7: p = 4'($urandom);
            8: len = $urandom_range(1, 3);
            9: begin p = 4'hF; len = $urandom_range(20, 60); end
            default: ;
         endcase
         hold(p, d, len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
